core_mem_responder: RTL and testbench
=====================================

CORE_MEM_RESPONDER -- requirements
Module: core_mem_responder

Interface
REQ-001 Parameter IMEM_DEPTH, default 64, instruction memory words (21 bit each), indexed by PC_out.
REQ-002 Parameter DMEM_DEPTH, default 256, data memory words (32 bit each), power of two, indexed by AR_out modulo DMEM_DEPTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 prog_we  input  1  program/preload write strobe.
REQ-006 prog_sel  input  1  preload target: 0 = instruction memory, 1 = data memory.
REQ-007 prog_addr  input  12  preload word address.
REQ-008 prog_data  input  32  preload data; bits [20:0] used for instruction memory.
REQ-009 start  input  1  run request pulse.
REQ-010 PC_out  input  6  core program counter.
REQ-011 AR_out  input  12  core data address.
REQ-012 DRAM_we  input  1  core data write enable.
REQ-013 DR_out  input  32  core write data.
REQ-014 End  input  1  core end-of-program flag.
REQ-015 Instruction  output  21  registered instruction word to core.
REQ-016 Data  output  32  registered data word to core.
REQ-017 core_en  output  1  core run enable, high only in RUN.
REQ-018 done  output  1  high only in DONE.

Function
REQ-019 State machine SHALL have states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on End sampled high; DONE->IDLE on start; otherwise hold.
REQ-020 Instruction SHALL equal imem[PC_out] one clock after PC_out is sampled (1-cycle latency), in every state; PC_out >= IMEM_DEPTH returns 21'b0.
REQ-021 Data SHALL equal dmem[AR_out mod DMEM_DEPTH] one clock after AR_out is sampled, in every state.
REQ-022 In RUN with DRAM_we high, dmem[AR_out mod DMEM_DEPTH] SHALL take DR_out at that edge; DRAM_we ignored in IDLE and DONE.
REQ-023 Simultaneous core write and read of the same address SHALL be write-first: Data shows DR_out next cycle.
REQ-024 A core write in the same cycle End is sampled SHALL be committed.
REQ-025 prog_we SHALL write only in IDLE; ignored in RUN/DONE; instruction preload with prog_addr >= IMEM_DEPTH SHALL be dropped; data preload wraps modulo DMEM_DEPTH.
REQ-026 start while RUN SHALL be ignored; start and prog_we together in IDLE: write committed, then RUN.
REQ-027 core_en and done SHALL be registered state decodes (change one clock after the causing event).

Reset
REQ-028 rst_n low SHALL force IDLE, Instruction = 0, Data = 0, core_en = 0, done = 0 immediately, regardless of clock.
REQ-029 Memory contents SHALL NOT be cleared by reset; reset mid-RUN abandons execution, preserved memory readable in IDLE.

Configuration
REQ-030 Macro CORE_MEM_ACCESS_COUNT_EN: when defined, outputs wr_count (16 bit, committed core writes) and run_cycles (16 bit, clocks spent in RUN) SHALL exist, clear on reset and on IDLE->RUN, saturate at 16'hFFFF.
REQ-031 Without CORE_MEM_ACCESS_COUNT_EN these ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-032 Preload imem[0] = 21'b010000101000000100010, start, PC_out = 0 -> core_en high next cycle, Instruction = 21'b010000101000000100010 one cycle after PC_out sampled.
REQ-033 Preload dmem[34] = 5, RUN, AR_out = 34 -> Data = 32'd5 next cycle; AR_out = 290 (DMEM_DEPTH 256) -> Data = 5.
REQ-034 RUN, DRAM_we = 1, AR_out = 7, DR_out = 32'hDEADBEEF -> Data = 32'hDEADBEEF next cycle (write-first); same strobe in IDLE -> dmem[7] unchanged.
REQ-035 RUN, End = 1 with DRAM_we = 1 to address 3, value 9 -> done = 1, core_en = 0 next cycle, dmem[3] = 9; prog_we then ignored until start returns to IDLE.
REQ-036 rst_n low mid-RUN -> outputs 0 asynchronously, state IDLE, prior dmem writes still readable.
REQ-037 With CORE_MEM_ACCESS_COUNT_EN, 10 RUN cycles and 3 writes -> run_cycles = 10, wr_count = 3; counters clear on next start from IDLE.

Source files
------------

// File: rtl/core_mem_responder.sv
// Instruction/data memory responder for a simple core: preload port, run-control FSM, registered reads.
// Optional access counters (wr_count, run_cycles) are enabled by defining CORE_MEM_ACCESS_COUNT_EN.
module core_mem_responder #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prog_we,
  input  logic        prog_sel,
  input  logic [11:0] prog_addr,
  input  logic [31:0] prog_data,
  input  logic        start,
  input  logic [5:0]  PC_out,
  input  logic [11:0] AR_out,
  input  logic        DRAM_we,
  input  logic [31:0] DR_out,
  input  logic        End,
  output logic [20:0] Instruction,
  output logic [31:0] Data,
  output logic        core_en,
  output logic        done
`ifdef CORE_MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] run_cycles
`endif
);

  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [20:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  logic [IAW-1:0] pc_idx, pa_iidx;
  logic [DAW-1:0] ar_idx, pa_didx;
  logic           pc_ok, pa_iok;
  logic           core_wr, prog_ok;

  // Data addresses wrap by truncation (depth is a power of two).
  assign pc_idx  = IAW'(PC_out);
  assign pa_iidx = IAW'(prog_addr);
  assign ar_idx  = DAW'(AR_out);
  assign pa_didx = DAW'(prog_addr);
  assign pc_ok   = 32'(PC_out) < 32'(IMEM_DEPTH);
  assign pa_iok  = 32'(prog_addr) < 32'(IMEM_DEPTH);

  assign core_wr = (state_q == RUN) && DRAM_we;
  assign prog_ok = (state_q == IDLE) && prog_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (End)   state_d = DONE;
      DONE:    if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decoding the next state keeps core_en/done aligned with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_en <= 1'b0;
      done    <= 1'b0;
    end else begin
      core_en <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

  // Storage is deliberately outside reset so contents survive an aborted run.
  always_ff @(posedge clk) begin
    if (prog_ok && !prog_sel && pa_iok) imem[pa_iidx] <= prog_data[20:0];
    if (core_wr)                        dmem[ar_idx]  <= DR_out;
    else if (prog_ok && prog_sel)       dmem[pa_didx] <= prog_data;
  end

  // A core write always targets the read address, so forwarding DR_out gives write-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Instruction <= '0;
      Data        <= '0;
    end else begin
      Instruction <= pc_ok ? imem[pc_idx] : '0;
      Data        <= core_wr ? DR_out : dmem[ar_idx];
    end
  end

`ifdef CORE_MEM_ACCESS_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count   <= '0;
      run_cycles <= '0;
    end else if (state_q == IDLE && start) begin
      wr_count   <= '0;
      run_cycles <= '0;
    end else begin
      if (state_q == RUN && run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
      if (core_wr && wr_count != 16'hFFFF)          wr_count   <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench for core_mem_responder: directed scenarios plus random traffic vs a reference model.
module tb_core_mem_responder;
  localparam int IMD = 48;
  localparam int DMD = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we, prog_sel, start, DRAM_we, End;
  logic [11:0] prog_addr, AR_out;
  logic [31:0] prog_data, DR_out;
  logic [5:0]  PC_out;
  logic [20:0] Instruction;
  logic [31:0] Data;
  logic        core_en, done;
`ifdef CORE_MEM_ACCESS_COUNT_EN
  logic [15:0] wr_count, run_cycles;
`endif

  core_mem_responder #(.IMEM_DEPTH(IMD), .DMEM_DEPTH(DMD)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_sel(prog_sel),
    .prog_addr(prog_addr), .prog_data(prog_data), .start(start), .PC_out(PC_out),
    .AR_out(AR_out), .DRAM_we(DRAM_we), .DR_out(DR_out), .End(End),
    .Instruction(Instruction), .Data(Data), .core_en(core_en), .done(done)
`ifdef CORE_MEM_ACCESS_COUNT_EN
    , .wr_count(wr_count), .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_mem;
    logic [20:0] instr;
    logic [31:0] data;
    logic        ce;
    logic        dn;
    int          wc;
    int          rc;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [20:0] m_imem [64];
  logic [31:0] m_dmem [DMD];
  int          m_mode = 0;  // 0 idle, 1 running, 2 finished
  int          m_wc = 0, m_rc = 0;
  bit          chk_mem_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts what the outputs show after the next rising edge.
  task automatic step(input bit s, input bit pw, input bit ps, input logic [11:0] pa,
                      input logic [31:0] pd, input logic [5:0] pc, input logic [11:0] ar,
                      input bit we, input logic [31:0] dr, input bit e);
    exp_t x;
    bit   wr;
    @(negedge clk);
    start = s; prog_we = pw; prog_sel = ps; prog_addr = pa; prog_data = pd;
    PC_out = pc; AR_out = ar; DRAM_we = we; DR_out = dr; End = e;
    x.chk_mem = chk_mem_en;
    x.instr   = (int'(pc) < IMD) ? m_imem[pc] : 21'b0;
    wr = (m_mode == 1) && we;
    if (wr) m_dmem[8'(int'(ar) % DMD)] = dr;
    x.data = m_dmem[8'(int'(ar) % DMD)];
    if (m_mode == 0 && pw) begin
      if (ps) m_dmem[8'(int'(pa) % DMD)] = pd;
      else if (int'(pa) < IMD) m_imem[6'(pa)] = pd[20:0];
    end
    if (m_mode == 0 && s) begin
      m_wc = 0; m_rc = 0;
    end else begin
      if (m_mode == 1 && m_rc < 65535) m_rc++;
      if (wr && m_wc < 65535) m_wc++;
    end
    case (m_mode)
      0: if (s) m_mode = 1;
      1: if (e) m_mode = 2;
      default: if (s) m_mode = 0;
    endcase
    x.ce = (m_mode == 1); x.dn = (m_mode == 2); x.wc = m_wc; x.rc = m_rc;
    q.push_back(x);
  endtask

  task automatic idle_cycle(input logic [5:0] pc, input logic [11:0] ar);
    step(0, 0, 0, 12'd0, 32'd0, pc, ar, 0, 32'd0, 0);
  endtask

  task automatic settle;
    @(posedge clk); #2;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("sb_core_en", 32'(core_en), 32'(x.ce));
        check("sb_done", 32'(done), 32'(x.dn));
        if (x.chk_mem) begin
          check("sb_instruction", 32'(Instruction), 32'(x.instr));
          check("sb_data", Data, x.data);
        end
`ifdef CORE_MEM_ACCESS_COUNT_EN
        check("sb_wr_count", 32'(wr_count), 32'(x.wc));
        check("sb_run_cycles", 32'(run_cycles), 32'(x.rc));
`endif
      end
    end
  end

  initial begin : stim
    logic [20:0] pat;
    pat = 21'b010000101000000100010;
    rst_n = 1'b0; start = 0; prog_we = 0; prog_sel = 0; prog_addr = '0; prog_data = '0;
    PC_out = '0; AR_out = '0; DRAM_we = 0; DR_out = '0; End = 0;
    #2;
    check("reset_instruction", 32'(Instruction), 32'd0);
    check("reset_data", Data, 32'd0);
    check("reset_core_en", 32'(core_en), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Fill both memories, then try out-of-range instruction writes that must be dropped.
    for (int i = 0; i < IMD; i++)
      step(0, 1, 0, 12'(i), $urandom, 6'($urandom), 12'($urandom), 0, 32'd0, 0);
    for (int i = 0; i < DMD; i++)
      step(0, 1, 1, 12'(i), $urandom, 6'($urandom), 12'($urandom), 0, 32'd0, 0);
    for (int i = IMD; i < 64; i++)
      step(0, 1, 0, 12'(i), 32'h1FFFFF, 6'($urandom), 12'($urandom), 0, 32'd0, 0);
    step(0, 1, 0, 12'd4095, 32'h1FFFFF, 6'd0, 12'd0, 0, 32'd0, 0);
    chk_mem_en = 1;
    for (int i = IMD; i < 64; i++) idle_cycle(6'(i), 12'd0);

    // Instruction fetch after start, data preload and address wrap.
    step(0, 1, 0, 12'd0, 32'(pat), 6'd0, 12'd0, 0, 32'd0, 0);
    step(0, 1, 1, 12'd34, 32'd5, 6'd0, 12'd0, 0, 32'd0, 0);
    step(1, 0, 0, 12'd0, 32'd0, 6'd0, 12'd34, 0, 32'd0, 0);
    settle;
    check("dir_core_en_after_start", 32'(core_en), 32'd1);
    check("dir_instr_pattern", 32'(Instruction), 32'(pat));
    check("dir_data_34", Data, 32'd5);
    step(0, 0, 0, 12'd0, 32'd0, 6'd1, 12'd290, 0, 32'd0, 0);
    settle;
    check("dir_data_290_wrap", Data, 32'd5);

    // Write-first in RUN, then End with a concurrent write, then ignored preload in DONE.
    step(1, 1, 1, 12'd7, 32'd1, 6'd2, 12'd7, 1, 32'hDEADBEEF, 0);
    settle;
    check("dir_write_first", Data, 32'hDEADBEEF);
    step(0, 0, 0, 12'd0, 32'd0, 6'd3, 12'd3, 1, 32'd9, 1);
    settle;
    check("dir_done_on_end", 32'(done), 32'd1);
    check("dir_core_en_off", 32'(core_en), 32'd0);
    step(0, 1, 1, 12'd3, 32'd77, 6'd4, 12'd3, 1, 32'd55, 0);
    idle_cycle(6'd5, 12'd3);
    settle;
    check("dir_end_write_kept", Data, 32'd9);
    step(1, 0, 0, 12'd0, 32'd0, 6'd0, 12'd0, 0, 32'd0, 0);
    settle;
    check("dir_done_to_idle", 32'(done), 32'd0);
    step(0, 0, 0, 12'd0, 32'd0, 6'd0, 12'd7, 1, 32'h12345678, 0);
    idle_cycle(6'd0, 12'd7);
    settle;
    check("dir_idle_write_ignored", Data, 32'hDEADBEEF);

`ifdef CORE_MEM_ACCESS_COUNT_EN
    step(1, 0, 0, 12'd0, 32'd0, 6'd0, 12'd0, 0, 32'd0, 0);
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, 12'd0, 32'd0, 6'(i), 12'(i), (i == 2 || i == 5 || i == 9), 32'(i), (i == 9));
    settle;
    check("dir_run_cycles_10", 32'(run_cycles), 32'd10);
    check("dir_wr_count_3", 32'(wr_count), 32'd3);
    step(1, 0, 0, 12'd0, 32'd0, 6'd0, 12'd0, 0, 32'd0, 0);
    step(1, 0, 0, 12'd0, 32'd0, 6'd0, 12'd0, 0, 32'd0, 0);
    settle;
    check("dir_run_cycles_clear", 32'(run_cycles), 32'd0);
    check("dir_wr_count_clear", 32'(wr_count), 32'd0);
    step(0, 0, 0, 12'd0, 32'd0, 6'd0, 12'd0, 1, 32'd0, 1);
    step(1, 0, 0, 12'd0, 32'd0, 6'd0, 12'd0, 0, 32'd0, 0);
`endif

    // Reset during a run: outputs clear at once, memory survives.
    if (m_mode != 1) step(1, 0, 0, 12'd0, 32'd0, 6'd0, 12'd0, 0, 32'd0, 0);
    step(0, 0, 0, 12'd0, 32'd0, 6'd9, 12'd100, 1, 32'hA5A5A5A5, 0);
    @(negedge clk);
    start = 0; prog_we = 0; DRAM_we = 0; End = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_instruction", 32'(Instruction), 32'd0);
    check("async_rst_data", Data, 32'd0);
    check("async_rst_core_en", 32'(core_en), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    m_mode = 0; m_wc = 0; m_rc = 0;
    #1 rst_n = 1'b1;
    idle_cycle(6'd0, 12'd100);
    settle;
    check("rst_mem_preserved", Data, 32'hA5A5A5A5);
    check("rst_state_idle", 32'(core_en), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), 1'($urandom),
           12'($urandom), $urandom, 6'($urandom), 12'($urandom),
           1'($urandom), $urandom, ($urandom_range(0, 11) == 0));

    @(posedge clk); #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
